// File: rtl/ps2_led_ctrl_if.sv
// PS/2 LED sequencer bus: RX byte stream in/out, TX byte handshake
// and LED request/status.
interface ps2_led_ctrl_if;
    logic [2:0] i_leds;
    logic       i_byte_en;
    logic [7:0] i_byte;
    logic       o_byte_en;
    logic [7:0] o_byte;
    logic       i_tx_ready;
    logic       o_tx_en;
    logic [7:0] o_tx_byte;
    logic       o_busy;
    logic       o_err;

    modport master (
        input  i_leds, i_byte_en, i_byte, i_tx_ready,
        output o_byte_en, o_byte, o_tx_en, o_tx_byte,
        output o_busy, o_err
    );

    modport slave (
        output i_leds, i_byte_en, i_byte, i_tx_ready,
        input  o_byte_en, o_byte, o_tx_en, o_tx_byte,
        input  o_busy, o_err
    );
endinterface

// File: rtl/ps2_led_ctrl.sv
// Host-side PS/2 "Set LEDs" sequencer: sends 0xED + LED byte on
// change, waits for ACK, retries on RESEND/timeout, filters ACK/RESEND.
module ps2_led_ctrl #(
    parameter int TIMEOUT   = 1_000_000,
    parameter int MAX_RETRY = 3,
    parameter int CNT_W     = 20
) (
    input logic           clk,
    input logic           i_rst_n,
    ps2_led_ctrl_if.master bus
);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [RW:0]      MAXR = (RW+1)'(MAX_RETRY);
    localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0] CMD = 8'hED;
    localparam logic [7:0] ACK = 8'hFA;
    localparam logic [7:0] NAK = 8'hFE;

    typedef enum logic [2:0] {
        IDLE, SEND_CMD, WAIT_ACK1, SEND_LED, WAIT_ACK2
    } state_t;

    state_t           state;
    logic [2:0]       r_leds;
    logic [2:0]       r_sent;
    logic [RW-1:0]    retry;
    logic [CNT_W-1:0] timer;
    logic             tx_en;
    logic [7:0]       tx_byte;
    logic             err;

    logic       waiting;
    logic       ack;
    logic       nak;
    logic       tmo;
    logic       last;
    logic [7:0] led_byte;

    assign waiting  = (state == WAIT_ACK1) || (state == WAIT_ACK2);
    assign ack      = bus.i_byte_en && (bus.i_byte == ACK);
    assign nak      = bus.i_byte_en && (bus.i_byte == NAK);
    assign tmo      = (timer == TMAX);
    assign last     = (({1'b0, retry} + 1'b1) >= MAXR);
    assign led_byte = {5'b0, r_leds};

    // ACK/RESEND are only ours while a response is awaited
    assign bus.o_byte_en = bus.i_byte_en
                         && !(waiting && (ack || nak));
    assign bus.o_byte    = bus.i_byte;
    assign bus.o_tx_en   = tx_en;
    assign bus.o_tx_byte = tx_byte;
    assign bus.o_busy    = (state != IDLE);
    assign bus.o_err     = err;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            r_leds  <= 3'b000;
            r_sent  <= 3'b000;
            retry   <= '0;
            timer   <= '0;
            tx_en   <= 1'b0;
            tx_byte <= 8'h00;
            err     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.i_leds != r_sent) begin
                        r_leds  <= bus.i_leds;
                        retry   <= '0;
                        state   <= SEND_CMD;
                        tx_en   <= 1'b1;
                        tx_byte <= CMD;
                    end
                end
                SEND_CMD, SEND_LED: begin
                    if (bus.i_tx_ready) begin
                        tx_en <= 1'b0;
                        timer <= '0;
                        state <= (state == SEND_CMD)
                               ? WAIT_ACK1 : WAIT_ACK2;
                    end
                end
                WAIT_ACK1, WAIT_ACK2: begin
                    timer <= timer + 1'b1;
                    if (ack) begin
                        if (state == WAIT_ACK1) begin
                            state   <= SEND_LED;
                            tx_en   <= 1'b1;
                            tx_byte <= led_byte;
                        end else begin
                            r_sent <= r_leds;
                            err    <= 1'b0;
                            state  <= IDLE;
                        end
                    end else if (nak || tmo) begin
                        retry <= retry + 1'b1;
                        if (last) begin
                            // give up on this value so IDLE won't spin on it
                            r_sent <= r_leds;
                            err    <= 1'b1;
                            state  <= IDLE;
                        end else if (nak && state == WAIT_ACK2) begin
                            state   <= SEND_LED;
                            tx_en   <= 1'b1;
                            tx_byte <= led_byte;
                        end else begin
                            state   <= SEND_CMD;
                            tx_en   <= 1'b1;
                            tx_byte <= CMD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_led_ctrl.sv
// Directed bench for ps2_led_ctrl: handshake, filtering, retry,
// timeout/abort, back-to-back updates and async reset.
module tb_ps2_led_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    ps2_led_ctrl_if bus ();

    ps2_led_ctrl #(
        .TIMEOUT(16), .MAX_RETRY(3), .CNT_W(5)
    ) dut (
        .clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs,
                       logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    // waits for a TX request, checks the byte, lets it be accepted
    task automatic wait_tx(string tag, logic [7:0] exp);
        int n = 0;
        while (bus.o_tx_en !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, 32'(bus.o_tx_en), 32'd1);
        chk(tag, 32'(bus.o_tx_byte), 32'(exp));
        if (bus.i_tx_ready) begin
            @(negedge clk);
            chk({tag, "_acc"}, 32'(bus.o_tx_en), 32'd0);
        end
    endtask

    task automatic inject(string tag, logic [7:0] b, logic fwd);
        bus.i_byte_en = 1'b1;
        bus.i_byte    = b;
        #1;
        chk({tag, "_fwd"}, 32'(bus.o_byte_en), 32'(fwd));
        if (fwd) chk({tag, "_byte"}, 32'(bus.o_byte), 32'(b));
        @(negedge clk);
        bus.i_byte_en = 1'b0;
    endtask

    task automatic wait_idle(string tag, logic exp_err);
        int n = 0;
        while (bus.o_busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
        chk({tag, "_err"}, 32'(bus.o_err), 32'(exp_err));
    endtask

    initial begin
        bus.i_leds     = 3'b100;
        bus.i_byte_en  = 1'b1;
        bus.i_byte     = 8'hFA;
        bus.i_tx_ready = 1'b1;
        step(2);
        // reset values; bytes pass straight through in IDLE
        chk("rst_tx_en", 32'(bus.o_tx_en), 32'd0);
        chk("rst_tx_byte", 32'(bus.o_tx_byte), 32'h00);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_err", 32'(bus.o_err), 32'd0);
        chk("rst_fwd", 32'(bus.o_byte_en), 32'd1);
        bus.i_byte_en = 1'b0;
        rst_n = 1'b1;

        // 1: basic transaction
        wait_tx("t1_cmd", 8'hED);
        chk("t1_busy", 32'(bus.o_busy), 32'd1);
        inject("t1_ack1", 8'hFA, 1'b0);
        wait_tx("t1_led", 8'h04);
        inject("t1_ack2", 8'hFA, 1'b0);
        wait_idle("t1_done", 1'b0);

        // 2 + 3: forward scan code while waiting; RESEND of LED byte
        bus.i_leds = 3'b001;
        wait_tx("t2_cmd", 8'hED);
        inject("t2_scan", 8'h1C, 1'b1);
        chk("t2_busy", 32'(bus.o_busy), 32'd1);
        chk("t2_notx", 32'(bus.o_tx_en), 32'd0);
        inject("t2_ack1", 8'hFA, 1'b0);
        wait_tx("t3_led", 8'h01);
        inject("t3_nak", 8'hFE, 1'b0);
        wait_tx("t3_relead", 8'h01);
        inject("t3_ack2", 8'hFA, 1'b0);
        wait_idle("t3_done", 1'b0);

        // 4: no response -> 3 attempts, abort
        bus.i_leds = 3'b010;
        wait_tx("t4_cmd0", 8'hED);
        step(15);
        chk("t4_early", 32'(bus.o_tx_en), 32'd0);
        step(1);
        chk("t4_tmo", 32'(bus.o_tx_en), 32'd1);
        wait_tx("t4_cmd1", 8'hED);
        wait_tx("t4_cmd2", 8'hED);
        wait_idle("t4_abort", 1'b1);
        step(30);
        chk("t4_quiet_tx", 32'(bus.o_tx_en), 32'd0);
        chk("t4_quiet_busy", 32'(bus.o_busy), 32'd0);
        bus.i_leds = 3'b011;
        wait_tx("t4_ok_cmd", 8'hED);
        inject("t4_ok_ack1", 8'hFA, 1'b0);
        wait_tx("t4_ok_led", 8'h03);
        inject("t4_ok_ack2", 8'hFA, 1'b0);
        wait_idle("t4_clr", 1'b0);

        // 5: change during transaction
        bus.i_leds = 3'b100;
        wait_tx("t5_cmd", 8'hED);
        bus.i_leds = 3'b110;
        inject("t5_ack1", 8'hFA, 1'b0);
        wait_tx("t5_led", 8'h04);
        inject("t5_ack2", 8'hFA, 1'b0);
        wait_tx("t5_cmd2", 8'hED);
        inject("t5_ack3", 8'hFA, 1'b0);
        wait_tx("t5_led2", 8'h06);
        inject("t5_ack4", 8'hFA, 1'b0);
        wait_idle("t5_done", 1'b0);

        // 6: async reset while stalled in SEND_LED
        bus.i_leds = 3'b101;
        wait_tx("t6_cmd", 8'hED);
        bus.i_tx_ready = 1'b0;
        inject("t6_ack1", 8'hFA, 1'b0);
        step(20);
        chk("t6_hold", 32'(bus.o_tx_en), 32'd1);
        chk("t6_hold_byte", 32'(bus.o_tx_byte), 32'h05);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_tx", 32'(bus.o_tx_en), 32'd0);
        chk("t6_rst_byte", 32'(bus.o_tx_byte), 32'h00);
        chk("t6_rst_busy", 32'(bus.o_busy), 32'd0);
        chk("t6_rst_err", 32'(bus.o_err), 32'd0);
        step(2);
        bus.i_tx_ready = 1'b1;
        rst_n = 1'b1;
        wait_tx("t6_restart", 8'hED);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end
endmodule
